ov7670_sccb_master: RTL and testbench
=====================================

// Module: ov7670_sccb_master
// PURPOSE
// - SCCB (I2C-like, write-only) master consuming the ov7670_registers command/advance/finished interface.
// - For each command {reg_addr[15:8], value[7:0]}: sends a 3-phase write DEV_ADDR, reg_addr, value to the camera, then pulses advance.
// - Sits between the register table and the OV7670 SIOC/SIOD pins; raises done when the table reports finished.
// PARAMETERS
// - CLK_FREQ_HZ      50_000_000  system clock frequency
// - SCCB_FREQ_HZ     100_000     SIOC frequency; quarter-period tick DIV = CLK_FREQ_HZ/(4*SCCB_FREQ_HZ), min 1
// - DEV_ADDR         8'h42       camera write address, sent MSB first
// - RESET_DELAY_CYC  1_000_000   clk cycles of wait after any 16'h1280 (COM7 soft reset) write
// - GAP_TICKS        8           idle quarter-ticks between consecutive transactions
// PORTS
// - clk         in   1   system clock
// - rst_n       in   1   asynchronous, active-low reset
// - command     in   16  {reg_addr, value} from register table
// - finished    in   1   table end marker (command == 16'hFFFF)
// - resend_req  in   1   1-clk pulse: restart full configuration
// - advance     out  1   1-clk pulse: request next table entry
// - resend      out  1   1-clk pulse to table: rewind to entry 0
// - busy        out  1   high while a transaction, gap or reset delay is in progress
// - done        out  1   high once finished sampled; held until reset or resend_req
// - sioc        out  1   SCCB clock, push-pull
// - siod_oe     out  1   1 = drive SIOD low; 0 = release (external pull-up gives 1)
// BEHAVIOUR
// - Reset (async): state=IDLE, sioc=1, siod_oe=0, advance=0, resend=0, busy=0, done=0, tick counter=0.
// - Tick counter runs only outside IDLE/DONE; one tick every DIV clks; all bus phases advance on ticks.
// - IDLE: on entry wait 2 clks (table registers command one clk after address), then sample.
//   finished=1 -> DONE; else latch 27-bit shift reg {DEV_ADDR,1'b1, reg_addr,1'b1, value,1'b1} -> START.
// - START (2 ticks): t0 siod_oe=1 with sioc=1; t1 sioc=0.
// - BIT x27, 4 ticks each: q0 sioc=0, siod_oe=~bit; q1 hold; q2 sioc=1; q3 hold, shift.
//   9th bit of each phase is don't-care: siod released, ACK never sampled, no retry.
// - STOP (4 ticks): q0 sioc=0, siod_oe=1; q1 sioc=1; q2 siod_oe=0; q3 hold.
// - Total SIOC activity per transaction = 114 ticks = 114*DIV clks.
// - After STOP: advance=1 for exactly 1 clk; if latched command==16'h1280 -> RST_WAIT for
//   RESET_DELAY_CYC clks, else GAP for GAP_TICKS ticks; then IDLE.
// - DONE: sioc=1, siod_oe=0, done=1, busy=0, no further advance pulses.
// - resend_req in IDLE or DONE: resend=1 for 1 clk, done=0, then IDLE (2-clk wait applies).
//   resend_req during START/BIT/STOP/GAP/RST_WAIT: latched, serviced on next IDLE entry, before sampling.
// - busy=1 in every state except IDLE and DONE.
// - Mid-operation reset: bus released immediately (sioc=1, siod_oe=0); no stop condition generated.
// TESTING
// - DIV=2, command=16'h1204: SIOD bit stream 0x42,x,0x12,x,0x04,x on SIOC rising edges; 1 advance pulse; 228 clks START->STOP end.
// - command=16'h1280: advance pulse, then no START for RESET_DELAY_CYC (set 100) clks; busy high throughout.
// - Drive ov7670_registers model through full table: 57 transactions, 57 advance pulses, then done=1, bus idle.
// - resend_req pulsed mid-BIT: transaction completes, resend pulses once, next transaction sends entry 0 (16'h1280).
// - rst_n asserted mid-BIT: sioc=1, siod_oe=0, all outputs at reset values in same cycle; restart from entry 0.
// - Start/stop check: SIOD only changes while SIOC=1 at start (1->0) and stop (0->1) conditions.

Source files
------------

// File: rtl/ov7670_sccb_if.sv
// Handshake between the OV7670 register table and the SCCB master, plus the camera SIOC/SIOD pins.
interface ov7670_sccb_if;
  logic [15:0] command;
  logic        finished;
  logic        resend_req;
  logic        advance;
  logic        resend;
  logic        busy;
  logic        done;
  logic        sioc;
  logic        siod_oe;

  modport master (
    input  command, finished, resend_req,
    output advance, resend, busy, done, sioc, siod_oe
  );

  modport slave (
    output command, finished, resend_req,
    input  advance, resend, busy, done, sioc, siod_oe
  );
endinterface

// File: rtl/ov7670_sccb_master.sv
// Write-only SCCB master: walks the register table, sending DEV_ADDR/reg/value per entry
// and pausing after each write (long pause after a COM7 soft reset).
module ov7670_sccb_master #(
  parameter int unsigned CLK_FREQ_HZ     = 50_000_000,
  parameter int unsigned SCCB_FREQ_HZ    = 100_000,
  parameter logic [7:0]  DEV_ADDR        = 8'h42,
  parameter int unsigned RESET_DELAY_CYC = 1_000_000,
  parameter int unsigned GAP_TICKS       = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  ov7670_sccb_if.master bus
);
  localparam int unsigned DIV_RAW   = CLK_FREQ_HZ / (4 * SCCB_FREQ_HZ);
  localparam int unsigned DIV       = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int unsigned CNT_W     = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned WAIT_MAX  = (RESET_DELAY_CYC > GAP_TICKS) ? RESET_DELAY_CYC : GAP_TICKS;
  localparam int unsigned WAIT_W    = $clog2(WAIT_MAX + 3);
  localparam int unsigned SR_W      = 27;
  localparam logic [15:0] CMD_RESET = 16'h1280;

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_BIT, S_STOP, S_GAP, S_RST_WAIT, S_DONE
  } state_t;

  state_t            r_state;
  logic [CNT_W-1:0]  r_tick_cnt;
  logic [WAIT_W-1:0] r_wait_cnt;
  logic [SR_W-1:0]   r_sr;
  logic [4:0]        r_bit_cnt;
  logic [1:0]        r_q;
  logic [15:0]       r_cmd;
  logic              r_pend;
  logic              r_sioc;
  logic              r_siod_oe;
  logic              r_advance;
  logic              r_resend;
  logic              r_busy;
  logic              r_done;
  logic              w_tick;

  assign w_tick      = (r_tick_cnt == CNT_W'(DIV - 1));
  assign bus.sioc    = r_sioc;
  assign bus.siod_oe = r_siod_oe;
  assign bus.advance = r_advance;
  assign bus.resend  = r_resend;
  assign bus.busy    = r_busy;
  assign bus.done    = r_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_tick_cnt <= '0;
      r_wait_cnt <= '0;
      r_sr       <= '0;
      r_bit_cnt  <= '0;
      r_q        <= '0;
      r_cmd      <= '0;
      r_pend     <= 1'b0;
      r_sioc     <= 1'b1;
      r_siod_oe  <= 1'b0;
      r_advance  <= 1'b0;
      r_resend   <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_advance <= 1'b0;
      r_resend  <= 1'b0;

      // Quarter-period tick, frozen while parked in IDLE/DONE
      if (r_state == S_IDLE || r_state == S_DONE || w_tick) r_tick_cnt <= '0;
      else                                                   r_tick_cnt <= r_tick_cnt + CNT_W'(1);

      if (bus.resend_req && r_state != S_IDLE && r_state != S_DONE) r_pend <= 1'b1;

      case (r_state)
        S_IDLE: begin
          // Rewind requests win over sampling; the table needs two clks to present entry 0
          if (bus.resend_req || r_pend) begin
            r_resend   <= 1'b1;
            r_pend     <= 1'b0;
            r_done     <= 1'b0;
            r_wait_cnt <= '0;
          end else if (r_wait_cnt != WAIT_W'(2)) begin
            r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
          end else if (bus.finished) begin
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_cmd     <= bus.command;
            r_sr      <= {DEV_ADDR, 1'b1, bus.command[15:8], 1'b1, bus.command[7:0], 1'b1};
            r_siod_oe <= 1'b1;
            r_sioc    <= 1'b1;
            r_q       <= '0;
            r_bit_cnt <= '0;
            r_busy    <= 1'b1;
            r_state   <= S_START;
          end
        end

        S_START: if (w_tick) begin
          if (r_q == 2'd0) begin
            r_q    <= 2'd1;
            r_sioc <= 1'b0;
          end else begin
            r_q       <= 2'd0;
            r_siod_oe <= ~r_sr[SR_W-1];
            r_state   <= S_BIT;
          end
        end

        S_BIT: if (w_tick) begin
          r_q <= r_q + 2'd1;
          case (r_q)
            2'd1: r_sioc <= 1'b1;
            2'd3: begin
              r_sioc <= 1'b0;
              if (r_bit_cnt == 5'(SR_W - 1)) begin
                r_siod_oe <= 1'b1;
                r_state   <= S_STOP;
              end else begin
                r_bit_cnt <= r_bit_cnt + 5'd1;
                r_sr      <= r_sr << 1;
                r_siod_oe <= ~r_sr[SR_W-2];
              end
            end
            default: ;
          endcase
        end

        S_STOP: if (w_tick) begin
          r_q <= r_q + 2'd1;
          case (r_q)
            2'd0: r_sioc    <= 1'b1;
            2'd1: r_siod_oe <= 1'b0;
            2'd3: begin
              r_advance  <= 1'b1;
              r_wait_cnt <= '0;
              r_state    <= (r_cmd == CMD_RESET) ? S_RST_WAIT : S_GAP;
            end
            default: ;
          endcase
        end

        S_GAP: if (w_tick) begin
          if (r_wait_cnt == WAIT_W'(GAP_TICKS - 1)) begin
            r_wait_cnt <= '0;
            r_busy     <= 1'b0;
            r_state    <= S_IDLE;
          end else begin
            r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
          end
        end

        // Counted in raw clks: the camera needs wall-clock time after a soft reset
        S_RST_WAIT: begin
          if (r_wait_cnt == WAIT_W'(RESET_DELAY_CYC - 1)) begin
            r_wait_cnt <= '0;
            r_busy     <= 1'b0;
            r_state    <= S_IDLE;
          end else begin
            r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
          end
        end

        S_DONE: if (bus.resend_req) begin
          r_resend   <= 1'b1;
          r_done     <= 1'b0;
          r_wait_cnt <= '0;
          r_state    <= S_IDLE;
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ov7670_sccb_master.sv
// Bench: register-table model drives the master; a bus-level decoder checks every frame and pulse.
`timescale 1ns/1ps
module tb_ov7670_sccb_master;
  localparam int unsigned CLK_HZ    = 800_000;
  localparam int unsigned SCCB_HZ   = 100_000;
  localparam int unsigned DIV       = CLK_HZ / (4 * SCCB_HZ);
  localparam int unsigned RST_CYC   = 100;
  localparam int unsigned GAP       = 8;
  localparam int unsigned N_ENTRIES = 57;

  logic clk = 1'b0;
  logic rst_n;
  ov7670_sccb_if bus();

  ov7670_sccb_master #(
    .CLK_FREQ_HZ(CLK_HZ), .SCCB_FREQ_HZ(SCCB_HZ), .DEV_ADDR(8'h42),
    .RESET_DELAY_CYC(RST_CYC), .GAP_TICKS(GAP)
  ) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  // Register table: address steps on advance, rewinds on resend, command lags address by one clk
  logic [15:0] rom [0:N_ENTRIES];
  logic [5:0]  t_addr;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      t_addr      <= '0;
      bus.command <= '0;
    end else begin
      bus.command <= rom[t_addr];
      if (bus.resend) t_addr <= '0;
      else if (bus.advance && t_addr != 6'(N_ENTRIES)) t_addr <= t_addr + 6'd1;
    end
  end
  assign bus.finished = (bus.command == 16'hFFFF);

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned cyc = 0, nbits = 0, start_cyc = 0, stop_cyc = 0, adv_cyc = 0, delay = 0;
  int unsigned cur_idx = 0, next_idx = 0, adv_count = 0, trans_count = 0;
  int unsigned resend_count = 0, req_out = 0;
  bit in_txn = 0, await_adv = 0, post_adv = 0, resend_since = 0;
  bit prev_sioc = 1, prev_siod = 1, prev_adv = 0, prev_resend = 0;
  logic [26:0] rx = '0;
  logic [15:0] last_cmd = '0, cur_cmd = '0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [26:0] frame(input logic [15:0] c);
    return {8'h42, 1'b1, c[15:8], 1'b1, c[7:0], 1'b1};
  endfunction

  // Bus-level reference: decode start/stop/bits, track expected table index and timing
  always @(negedge clk) begin
    logic siod;
    int unsigned k;
    cyc++;
    if (!rst_n) begin
      check("reset_outputs", 32'({bus.sioc, bus.siod_oe, bus.advance, bus.resend, bus.busy, bus.done}),
            32'b100000);
      in_txn = 0; await_adv = 0; post_adv = 0; resend_since = 0;
      prev_sioc = 1; prev_siod = 1; prev_adv = 0; prev_resend = 0;
      next_idx = 0; req_out = 0; nbits = 0;
    end else begin
      siod = ~bus.siod_oe;
      k = cyc - adv_cyc;
      if (bus.done) begin
        check("done_only_after_table", 32'(next_idx == N_ENTRIES && !in_txn && !await_adv), 32'd1);
        check("done_not_busy", 32'(bus.busy), 32'd0);
      end
      if (prev_sioc && bus.sioc && prev_siod && !siod) begin
        check("start_outside_txn", 32'(in_txn || await_adv), 32'd0);
        if (post_adv && !resend_since) begin
          check("start_spacing", 32'(k >= delay + 2 && k <= delay + 3), 32'd1);
          if (cur_cmd == 16'h1280) check("reset_delay_respected", 32'(k >= 100), 32'd1);
        end
        in_txn = 1; post_adv = 0; nbits = 0; rx = '0; start_cyc = cyc;
        cur_idx = next_idx; cur_cmd = rom[cur_idx]; next_idx++;
      end else if (prev_sioc && bus.sioc && !prev_siod && siod) begin
        check("stop_inside_txn", 32'(in_txn), 32'd1);
        check("sioc_rises_per_txn", nbits, 32'd28);
        check("frame_bits", 32'(rx), 32'(frame(cur_cmd)));
        if (cur_idx == 0)
          check("frame_entry0_literal", 32'(rx), 32'({8'h42, 1'b1, 8'h12, 1'b1, 8'h80, 1'b1}));
        if (cur_idx == 1)
          check("frame_entry1_literal", 32'(rx), 32'({8'h42, 1'b1, 8'h12, 1'b1, 8'h04, 1'b1}));
        last_cmd = {rx[17:10], rx[8:1]};
        in_txn = 0; await_adv = 1; stop_cyc = cyc; trans_count++;
      end else if (!prev_sioc && bus.sioc) begin
        check("sioc_rise_inside_txn", 32'(in_txn), 32'd1);
        if (nbits < 27) rx = {rx[25:0], siod};
        nbits++;
      end
      if (bus.advance) begin
        check("advance_one_clk", 32'(prev_adv), 32'd0);
        check("advance_after_stop", 32'(await_adv), 32'd1);
        check("start_to_advance_clks", cyc - start_cyc, 32'd228);
        check("stop_to_advance_clks", cyc - stop_cyc, 32'(2 * DIV));
        await_adv = 0; post_adv = 1; resend_since = 0; adv_cyc = cyc; adv_count++; k = 0;
        delay = (cur_cmd == 16'h1280) ? RST_CYC : GAP * DIV;
      end
      if (bus.resend) begin
        check("resend_one_clk", 32'(prev_resend), 32'd0);
        check("resend_requested", 32'(req_out > 0), 32'd1);
        check("resend_while_not_busy", 32'(bus.busy), 32'd0);
        check("resend_clears_done", 32'(bus.done), 32'd0);
        if (req_out > 0) req_out--;
        resend_count++; resend_since = 1;
      end
      check("busy", 32'(bus.busy), 32'(in_txn || await_adv || (post_adv && k < delay)));
      if (!in_txn) check("bus_idle", 32'({bus.sioc, bus.siod_oe}), 32'b10);
      if (bus.resend_req) begin
        next_idx = 0;
        req_out++;
      end
      prev_sioc = bus.sioc; prev_siod = siod; prev_adv = bus.advance; prev_resend = bus.resend;
    end
  end

  task automatic wait_done(input int unsigned bound, input string name);
    int unsigned i = 0;
    while (!bus.done && i < bound) begin @(negedge clk); i++; end
    check(name, 32'(bus.done), 32'd1);
  endtask

  task automatic wait_mid_bit(input int unsigned idx, input int unsigned bit_at, input string name);
    int unsigned i = 0;
    while (!(in_txn && cur_idx == idx && nbits >= bit_at) && i < 20000) begin @(negedge clk); i++; end
    check(name, 32'(in_txn && cur_idx == idx && nbits >= bit_at), 32'd1);
  endtask

  task automatic wait_adv(input int unsigned target, input string name);
    int unsigned i = 0;
    while (adv_count < target && i < 5000) begin @(negedge clk); i++; end
    check(name, 32'(adv_count >= target), 32'd1);
  endtask

  task automatic pulse_resend();
    @(posedge clk); #1 bus.resend_req = 1'b1;
    @(posedge clk); #1 bus.resend_req = 1'b0;
  endtask

  initial begin
    int unsigned j, b, a0;
    rom[0] = 16'h1280;
    rom[1] = 16'h1204;
    for (int i = 2; i < N_ENTRIES; i++) begin
      logic [15:0] v;
      do v = 16'($urandom); while (v == 16'h1280 || v == 16'hFFFF);
      rom[i] = v;
    end
    rom[N_ENTRIES] = 16'hFFFF;
    rst_n = 1'b0;
    bus.resend_req = 1'b0;
    repeat (3) @(negedge clk);
    @(posedge clk); #1 rst_n = 1'b1;

    wait_done(20000, "phase1_done");
    check("phase1_advances", adv_count, 32'd57);
    check("phase1_txns", trans_count, 32'd57);
    check("phase1_bus_idle", 32'({bus.sioc, bus.siod_oe, bus.busy}), 32'b100);

    pulse_resend();
    j = $urandom_range(2, 8);
    b = $urandom_range(2, 20);
    wait_mid_bit(j, b, "phase2_mid_bit_reached");
    a0 = adv_count;
    pulse_resend();
    wait_adv(a0 + 2, "phase2_restart_advances");
    check("resend_restarts_at_entry0", 32'(last_cmd), 32'h1280);
    check("phase2_resend_pulses", resend_count, 32'd2);
    wait_done(20000, "phase2_done");
    check("phase2_advances", adv_count, 32'(57 + j + 1 + 57));

    pulse_resend();
    j = $urandom_range(1, 4);
    b = $urandom_range(2, 20);
    wait_mid_bit(j, b, "phase3_mid_bit_reached");
    @(posedge clk); #1 rst_n = 1'b0;
    #1 check("rst_mid_bit_outputs",
             32'({bus.sioc, bus.siod_oe, bus.advance, bus.resend, bus.busy, bus.done}), 32'b100000);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    a0 = adv_count;
    wait_adv(a0 + 2, "phase3_restart_advances");
    check("restart_second_entry", 32'(last_cmd), 32'h1204);
    check("phase3_resend_pulses", resend_count, 32'd3);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
